// File: rtl/alu_pkg.sv
// Shared definitions for the alu_4bit command issuer.
//   - Opcode constants understood by alu_4bit; anything above OP_MAX is illegal.
//   - Issuer FSM state encoding.
//   - Command record carried through the command FIFO.
// ALU_W and TAG_W fix the command record layout. The W and TAGW parameters of
// alu_cmd_issuer must be left equal to them.
package alu_pkg;

    localparam int ALU_W = 4;
    localparam int TAG_W = 3;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_MAX = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_MAX);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO of cmd_t records.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset (flushes).
//   push, wdata  write request and record; ignored while full.
//   pop          read request; ignored while empty. rdata always shows the head.
//   full, empty  occupancy flags derived from the pointer wrap bit.
//   count        number of stored entries (0..DEPTH).
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     wdata,
    input  logic                     pop,
    output cmd_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Equal index with differing wrap bits means the write side has lapped the read side.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands, drives them into the combinational
// alu_4bit through registered operands, waits SETTLE cycles, captures the result
// and zero flag, and returns them with the command tag in command order.
// Ports:
//   clk, rst                       clock, synchronous active-high reset.
//   cmd_valid/cmd_ready            command handshake; cmd_a, cmd_b, cmd_op, cmd_tag.
//   alu_A, alu_B, alu_op           registered drives into alu_4bit.
//   alu_result, alu_ZF             combinational outputs of alu_4bit.
//   rsp_valid/rsp_ready            response handshake; rsp_result, rsp_zf, rsp_err, rsp_tag.
//   busy                           FIFO non-empty or FSM not idle.
//   op_count                       legal operations completed, wraps at 256.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int W      = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int TAGW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [W-1:0]    cmd_a,
    input  logic [W-1:0]    cmd_b,
    input  logic [3:0]      cmd_op,
    input  logic [TAGW-1:0] cmd_tag,
    output logic [W-1:0]    alu_A,
    output logic [W-1:0]    alu_B,
    output logic [3:0]      alu_op,
    input  logic [W-1:0]    alu_result,
    input  logic            alu_ZF,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_result,
    output logic            rsp_zf,
    output logic            rsp_err,
    output logic [TAGW-1:0] rsp_tag,
    output logic            busy,
    output logic [7:0]      op_count
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t            state;
    state_t            state_nxt;
    cmd_t              wr_cmd;
    cmd_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              push;
    logic              pop;
    logic [3:0]        settle_cnt;
    logic [TAGW-1:0]   cur_tag;

    // cmd_ready is forced low for the whole time rst is held.
    assign cmd_ready = !fifo_full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign wr_cmd    = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    // Illegal opcodes never touch the ALU; they answer immediately.
                    state_nxt = is_legal(head.op) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                if (settle_cnt == 4'd0) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers. Everything is held outside the load points, so the ALU
    // drives stay put until the next pop and rsp_* stay put while back-pressured.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_op     <= '0;
            rsp_result <= '0;
            rsp_zf     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_tag    <= '0;
            op_count   <= '0;
            settle_cnt <= '0;
            cur_tag    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (is_legal(head.op)) begin
                            alu_A      <= head.a;
                            alu_B      <= head.b;
                            alu_op     <= head.op;
                            cur_tag    <= head.tag;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_zf     <= 1'b0;
                            rsp_tag    <= head.tag;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_zf     <= alu_ZF;
                        rsp_err    <= 1'b0;
                        rsp_tag    <= cur_tag;
                        op_count   <= op_count + 8'd1;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance, SETTLE=1
    logic       cmd_valid1 = 1'b0, cmd_ready1;
    logic [3:0] cmd_a1 = '0, cmd_b1 = '0, cmd_op1 = '0;
    logic [2:0] cmd_tag1 = '0;
    logic [3:0] alu_A1, alu_B1, alu_op1, alu_result1;
    logic       alu_ZF1;
    logic       rsp_valid1, rsp_ready1 = 1'b1, rsp_zf1, rsp_err1, busy1;
    logic [3:0] rsp_result1;
    logic [2:0] rsp_tag1;
    logic [7:0] op_count1;

    // Second instance, SETTLE=3
    logic       cmd_valid3 = 1'b0, cmd_ready3;
    logic [3:0] cmd_a3 = '0, cmd_b3 = '0, cmd_op3 = '0;
    logic [2:0] cmd_tag3 = '0;
    logic [3:0] alu_A3, alu_B3, alu_op3, alu_result3;
    logic       alu_ZF3;
    logic       rsp_valid3, rsp_ready3 = 1'b1, rsp_zf3, rsp_err3, busy3;
    logic [3:0] rsp_result3;
    logic [2:0] rsp_tag3;
    logic [7:0] op_count3;

    // Behavioural stand-in for alu_4bit
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            4'd8:    return a + 4'd1;
            4'd9:    return a - 4'd1;
            4'd10:   return (a > b) ? a : b;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_result1 = alu_f(alu_A1, alu_B1, alu_op1);
    assign alu_ZF1     = (alu_result1 == 4'd0);
    assign alu_result3 = alu_f(alu_A3, alu_B3, alu_op3);
    assign alu_ZF3     = (alu_result3 == 4'd0);

    alu_cmd_issuer #(.W(4), .DEPTH(4), .SETTLE(1), .TAGW(3)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_op(cmd_op1), .cmd_tag(cmd_tag1),
        .alu_A(alu_A1), .alu_B(alu_B1), .alu_op(alu_op1),
        .alu_result(alu_result1), .alu_ZF(alu_ZF1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1),
        .rsp_zf(rsp_zf1), .rsp_err(rsp_err1), .rsp_tag(rsp_tag1),
        .busy(busy1), .op_count(op_count1)
    );

    alu_cmd_issuer #(.W(4), .DEPTH(4), .SETTLE(3), .TAGW(3)) u3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3), .cmd_tag(cmd_tag3),
        .alu_A(alu_A3), .alu_B(alu_B3), .alu_op(alu_op3),
        .alu_result(alu_result3), .alu_ZF(alu_ZF3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_zf(rsp_zf3), .rsp_err(rsp_err3), .rsp_tag(rsp_tag3),
        .busy(busy3), .op_count(op_count3)
    );

    typedef struct {
        logic [3:0] res;
        logic       zf;
        logic       err;
        logic [2:0] tag;
        logic       legal;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   rr_mode = 1'b0;
    bit   gap_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expectation on every response handshake.
    exp_t       e;
    int         ocnt = 0;
    bit         snap_ok = 1'b0;
    logic [8:0] snap;
    bit         have_last = 1'b0;
    int         last_cyc = 0;

    always @(negedge clk) begin
        if (!gap_chk) have_last = 1'b0;
        if (rst) begin
            q.delete();
            ocnt    = 0;
            snap_ok = 1'b0;
        end else if (rsp_valid1) begin
            if (snap_ok) chk("rsp_stable", {rsp_result1, rsp_zf1, rsp_err1, rsp_tag1}, snap);
            if (rsp_ready1) begin
                snap_ok = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_result", rsp_result1, e.res);
                    chk("rsp_zf", rsp_zf1, e.zf);
                    chk("rsp_err", rsp_err1, e.err);
                    chk("rsp_tag", rsp_tag1, e.tag);
                    if (e.legal) ocnt = (ocnt + 1) % 256;
                    chk("op_count", op_count1, ocnt);
                    if (gap_chk) begin
                        if (have_last) chk("rsp_gap", cyc - last_cyc, 3);
                        last_cyc  = cyc;
                        have_last = 1'b1;
                    end
                end
            end else begin
                snap    = {rsp_result1, rsp_zf1, rsp_err1, rsp_tag1};
                snap_ok = 1'b1;
            end
        end else begin
            snap_ok = 1'b0;
        end
    end

    // Random back-pressure generator
    initial forever begin
        @(posedge clk);
        #1;
        if (rr_mode) rsp_ready1 = ($urandom % 2) == 0;
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op, input logic [2:0] tag);
        exp_t x;
        bit   ok;
        x.legal = (op <= 4'd10);
        x.res   = x.legal ? alu_f(a, b, op) : 4'd0;
        x.zf    = x.legal && (x.res == 4'd0);
        x.err   = !x.legal;
        x.tag   = tag;
        cmd_valid1 = 1'b1;
        cmd_a1 = a; cmd_b1 = b; cmd_op1 = op; cmd_tag1 = tag;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            chk("cmd_accept_timeout", 0, 1);
            cmd_valid1 = 1'b0;
            return;
        end
        q.push_back(x);
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy1 && !rsp_valid1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    logic [3:0] sA, sB, sOp;
    logic [7:0] sCnt;
    int         seen;
    int         nlegal;
    logic [3:0] rop;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready1, 0);
        chk("reset_rsp_valid", rsp_valid1, 0);
        chk("reset_busy", busy1, 0);
        chk("reset_alu", {alu_A1, alu_B1, alu_op1}, 0);
        chk("reset_rsp", {rsp_result1, rsp_zf1, rsp_err1, rsp_tag1}, 0);
        chk("reset_op_count", op_count1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready1, 1);

        // SETTLE=3: operands held exactly three cycles before capture
        @(posedge clk);
        #1;
        cmd_valid3 = 1'b1; cmd_a3 = 4'd7; cmd_b3 = 4'd2; cmd_op3 = 4'd1; cmd_tag3 = 3'd5;
        @(posedge clk);
        #1 cmd_valid3 = 1'b0;
        @(negedge clk);
        chk("s3_alu_not_loaded", alu_A3, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("s3_alu_hold", {alu_A3, alu_B3, alu_op3}, {4'd7, 4'd2, 4'd1});
            chk("s3_no_rsp_yet", rsp_valid3, 0);
        end
        @(negedge clk);
        chk("s3_rsp_valid", rsp_valid3, 1);
        chk("s3_rsp_result", rsp_result3, 5);
        chk("s3_rsp_tag", rsp_tag3, 5);
        chk("s3_op_count", op_count3, 1);

        // Single ADD with latency
        @(posedge clk);
        #1;
        send(4'b0101, 4'b0011, 4'b0000, 3'd1);
        @(posedge clk);
        @(negedge clk);
        chk("add_alu_A", alu_A1, 4'b0101);
        chk("add_alu_op", alu_op1, 4'b0000);
        chk("add_rsp_not_yet", rsp_valid1, 0);
        @(negedge clk);
        chk("add_rsp_valid", rsp_valid1, 1);
        chk("add_rsp_result", rsp_result1, 4'b1000);
        wait_idle();

        // XOR giving zero, then a few random legal commands
        @(posedge clk);
        #1;
        send(4'b1010, 4'b1010, 4'b0100, 3'd2);
        for (int i = 0; i < 6; i++) send(4'($urandom), 4'($urandom), 4'($urandom_range(0, 10)), 3'($urandom));
        wait_idle();

        // Back-pressure: FIFO fills, fifth queued command stalls, then drains in order
        @(posedge clk);
        #1 rsp_ready1 = 1'b0;
        fork
            begin
                for (int t = 0; t < 6; t++) send(4'($urandom), 4'($urandom), 4'($urandom_range(0, 10)), 3'(t));
            end
            begin
                repeat (12) @(negedge clk);
                chk("full_cmd_ready", cmd_ready1, 0);
                chk("full_busy", busy1, 1);
                @(posedge clk);
                #1;
                gap_chk    = 1'b1;
                rsp_ready1 = 1'b1;
            end
        join
        wait_idle();
        gap_chk = 1'b0;

        // Illegal opcode
        @(posedge clk);
        #1 rsp_ready1 = 1'b0;
        sA = alu_A1; sB = alu_B1; sOp = alu_op1; sCnt = op_count1;
        send(4'd3, 4'd9, 4'b1101, 3'd6);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("ill_rsp_valid", rsp_valid1, 1);
        chk("ill_rsp_err", rsp_err1, 1);
        chk("ill_rsp_result", rsp_result1, 0);
        chk("ill_rsp_tag", rsp_tag1, 6);
        chk("ill_alu_unchanged", {alu_A1, alu_B1, alu_op1}, {sA, sB, sOp});
        chk("ill_op_count", op_count1, sCnt);
        @(posedge clk);
        #1 rsp_ready1 = 1'b1;
        wait_idle();

        // Reset during ISSUE with two commands still queued
        @(posedge clk);
        #1 rsp_ready1 = 1'b0;
        for (int i = 0; i < 4; i++) send(4'($urandom), 4'($urandom), 4'($urandom_range(0, 10)), 3'(i));
        rsp_ready1 = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_busy_before_reset", busy1, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", busy1, 0);
        chk("post_reset_op_count", op_count1, 0);
        chk("post_reset_cmd_ready", cmd_ready1, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid1) seen++;
            @(negedge clk);
        end
        chk("no_rsp_after_reset", seen, 0);

        // Random traffic with random back-pressure until 256 legal ops wrap op_count
        @(posedge clk);
        #1 rr_mode = 1'b1;
        nlegal = 0;
        while (nlegal < 256) begin
            rop = (($urandom % 8) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            if (rop <= 4'd10) nlegal++;
            send(4'($urandom), 4'($urandom), rop, 3'($urandom));
        end
        wait_idle();
        rr_mode = 1'b0;
        #2 rsp_ready1 = 1'b1;
        chk("op_count_wrap", op_count1, 0);
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
